vector_mem_sequencer: RTL and testbench
=======================================

Name: vector_mem_sequencer

Overview:
- Multi-cycle memory-stage sequencer between the EX_MEM pipe register and the byte-wide data memory.
- Serialises one scalar access or one I-lane vector access into consecutive single-lane memory transactions.
- Gathers read data into a lane vector and reports completion through mem_finished_o.
- Holds the pipeline with stall_o while an access is in flight.

Parameters:
- I, 4, number of vector lanes
- L, 8, lane / memory data width in bits
- A, 32, memory address width in bits

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- start_i  in  1  request from MEM stage; sampled only in IDLE
- op_type_i  in  1  1 = vector (I lanes), 0 = scalar (1 lane)
- op_source_i  in  1  store data select: 1 = rd2 operand, 0 = ALU result
- write_enable_i  in  1  1 = store, 0 = load
- address_i  in  A  base address
- alu_result_v_i  in  I*L  vector ALU result, lane k at bits [k*L +: L]
- rd2_v_i  in  I*L  vector register operand
- alu_result_s_i  in  L  scalar ALU result (low byte)
- rd2_s_i  in  L  scalar register operand (low byte)
- mem_addr_o  out  A  data memory address
- mem_wdata_o  out  L  data memory write data
- mem_we_o  out  1  data memory write strobe
- mem_rdata_i  in  L  data memory read data; synchronous, valid the cycle after address
- vector_o  out  I*L  gathered vector load result
- scalar_o  out  L  scalar load result
- mem_finished_o  out  1  one-cycle completion pulse
- stall_o  out  1  freeze upstream pipes

Behaviour:
- Reset (async, RST=1):
  - state = IDLE; count = 0.
  - vector_o = 0, scalar_o = 0, mem_finished_o = 0.
  - mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - Reset mid-access aborts the access immediately; no further writes are issued and no partial read data is retained.
- FSM states: IDLE, ACCESS, DRAIN, DONE.
- Access length: N = I when op_type is 1, N = 1 when op_type is 0.
- IDLE:
  - If start_i=1, latch op_type, write_enable, address_i as base, and the store data. Store data is rd2 when op_source_i=1, ALU result when op_source_i=0.
  - Clear count; go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS: each cycle
  - mem_addr_o = base + count, modulo 2^A (wrap-around allowed).
  - mem_we_o = latched write_enable.
  - mem_wdata_o = store lane[count].
  - For loads, mem_rdata_i is captured into gather lane[count-1] when count > 0.
  - count increments each cycle.
  - After the cycle with count == N-1: go to DRAIN for a load, to DONE for a store.
- DRAIN:
  - Capture mem_rdata_i into gather lane[N-1]; go to DONE.
  - mem_we_o = 0.
- DONE:
  - mem_finished_o = 1 for exactly this cycle.
  - Vector load: vector_o is updated from the gather buffer. Scalar load: scalar_o is updated from lane 0.
  - Stores leave vector_o and scalar_o unchanged.
  - Return to IDLE; start_i in this cycle is ignored.
- Outside ACCESS: mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
- vector_o and scalar_o hold their values until the next load completes.
- stall_o = (state != IDLE) || start_i (combinational), so the pipe freezes in the request cycle. It is deasserted in the cycle after DONE.
- Latency from the start cycle t0 to the mem_finished_o cycle:
  - vector store I+1
  - vector load I+2
  - scalar store 2
  - scalar load 3
- Back-to-back: a new start_i is accepted in the first IDLE cycle after DONE.
- start_i held high continuously produces one access per IDLE entry. There are no duplicate accesses within one request.

Test Plan:
- Reset during vector store at count=2 (I=4): mem_we_o drops in the same cycle. Exactly 2 writes are logged; state is IDLE; mem_finished_o is never pulsed.
- Vector store, base 0x10, rd2_v=0x44332211, op_source=1 → writes 0x11@0x10, 0x22@0x11, 0x33@0x12, 0x44@0x13. mem_finished_o pulses at t0+5; stall_o is high t0..t0+5.
- Vector load, base 0x10, after the above → vector_o=0x44332211 at t0+6; mem_finished_o is a single pulse; mem_we_o is never 1.
- Scalar store alu_result_s=0xA5 to 0x20 (op_source=0), then scalar load 0x20 → scalar_o=0xA5 three cycles after the second start. vector_o is unchanged.
- Address wrap, base 0xFFFFFFFE vector store → addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- start_i held high across DONE → the second access begins only after the IDLE cycle. There is exactly one mem_finished_o per access.

Source files
------------

// File: rtl/vector_mem_sequencer.sv
// Memory-stage sequencer: splits a scalar or I-lane vector access into single-lane
// transactions on a byte-wide synchronous memory and gathers the load data.
module vector_mem_sequencer #(
  parameter int I = 4,
  parameter int L = 8,
  parameter int A = 32
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start_i,
  input  logic           op_type_i,
  input  logic           op_source_i,
  input  logic           write_enable_i,
  input  logic [A-1:0]   address_i,
  input  logic [I*L-1:0] alu_result_v_i,
  input  logic [I*L-1:0] rd2_v_i,
  input  logic [L-1:0]   alu_result_s_i,
  input  logic [L-1:0]   rd2_s_i,
  output logic [A-1:0]   mem_addr_o,
  output logic [L-1:0]   mem_wdata_o,
  output logic           mem_we_o,
  input  logic [L-1:0]   mem_rdata_i,
  output logic [I*L-1:0] vector_o,
  output logic [L-1:0]   scalar_o,
  output logic           mem_finished_o,
  output logic           stall_o
);

  localparam int CW = (I > 1) ? $clog2(I) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t         state_r;
  logic [CW-1:0]  count_r;
  logic [A-1:0]   base_r;
  logic [I*L-1:0] store_r;
  logic [I*L-1:0] gather_r;
  logic           is_vec_r;
  logic           we_r;

  logic [I*L-1:0] store_sel_s;
  logic [I*L-1:0] gather_next_s;
  logic [CW-1:0]  next_count_s;
  logic [CW-1:0]  capture_idx_s;
  logic           capture_en_s;
  logic           last_s;

  function automatic logic [L-1:0] lane_of(input logic [I*L-1:0] vec, input logic [CW-1:0] idx);
    lane_of = {L{1'b0}};
    for (int k = 0; k < I; k++) begin
      if (idx == CW'(k)) lane_of = vec[k*L +: L];
    end
  endfunction

  assign stall_o = (state_r != IDLE) || start_i;

  // Store data selection; a scalar occupies lane 0 only.
  always_comb begin
    store_sel_s = {(I*L){1'b0}};
    if (op_type_i) begin
      if (op_source_i) store_sel_s = rd2_v_i;
      else             store_sel_s = alu_result_v_i;
    end else begin
      if (op_source_i) store_sel_s[L-1:0] = rd2_s_i;
      else             store_sel_s[L-1:0] = alu_result_s_i;
    end
  end

  // Read data trails the address by one cycle, so ACCESS fills lane count-1 and DRAIN the last lane.
  always_comb begin
    next_count_s  = count_r + CW'(1);
    last_s        = is_vec_r ? (count_r == CW'(I - 1)) : (count_r == {CW{1'b0}});
    capture_en_s  = 1'b0;
    capture_idx_s = count_r;
    gather_next_s = gather_r;
    case (state_r)
      ACCESS: begin
        if (!we_r && (count_r != {CW{1'b0}})) begin
          capture_en_s  = 1'b1;
          capture_idx_s = count_r - CW'(1);
        end else begin
          capture_en_s  = 1'b0;
        end
      end
      DRAIN:   capture_en_s = 1'b1;
      default: capture_en_s = 1'b0;
    endcase
    if (capture_en_s) begin
      for (int k = 0; k < I; k++) begin
        if (capture_idx_s == CW'(k)) gather_next_s[k*L +: L] = mem_rdata_i;
      end
    end else begin
      gather_next_s = gather_r;
    end
  end

  // Sequencer FSM; memory-side outputs are registered one step ahead of the state they belong to.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r        <= IDLE;
      count_r        <= {CW{1'b0}};
      base_r         <= {A{1'b0}};
      store_r        <= {(I*L){1'b0}};
      gather_r       <= {(I*L){1'b0}};
      is_vec_r       <= 1'b0;
      we_r           <= 1'b0;
      mem_addr_o     <= {A{1'b0}};
      mem_wdata_o    <= {L{1'b0}};
      mem_we_o       <= 1'b0;
      vector_o       <= {(I*L){1'b0}};
      scalar_o       <= {L{1'b0}};
      mem_finished_o <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          mem_finished_o <= 1'b0;
          if (start_i) begin
            state_r     <= ACCESS;
            count_r     <= {CW{1'b0}};
            base_r      <= address_i;
            is_vec_r    <= op_type_i;
            we_r        <= write_enable_i;
            store_r     <= store_sel_s;
            gather_r    <= {(I*L){1'b0}};
            mem_addr_o  <= address_i;
            mem_we_o    <= write_enable_i;
            mem_wdata_o <= store_sel_s[L-1:0];
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          gather_r <= gather_next_s;
          if (last_s) begin
            state_r        <= we_r ? DONE : DRAIN;
            mem_addr_o     <= {A{1'b0}};
            mem_wdata_o    <= {L{1'b0}};
            mem_we_o       <= 1'b0;
            mem_finished_o <= we_r;
          end else begin
            count_r     <= next_count_s;
            mem_addr_o  <= base_r + {{(A-CW){1'b0}}, next_count_s};
            mem_wdata_o <= lane_of(store_r, next_count_s);
            mem_we_o    <= we_r;
          end
        end
        DRAIN: begin
          gather_r       <= gather_next_s;
          state_r        <= DONE;
          mem_finished_o <= 1'b1;
          if (is_vec_r) vector_o <= gather_next_s;
          else          scalar_o <= gather_next_s[L-1:0];
        end
        DONE: begin
          state_r        <= IDLE;
          mem_finished_o <= 1'b0;
        end
        default: begin
          state_r        <= IDLE;
          mem_finished_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Randomized and directed bench for vector_mem_sequencer against a byte-array reference model.
module tb_vector_mem_sequencer;

  localparam int I = 4;
  localparam int L = 8;
  localparam int A = 32;

  logic           CLK;
  logic           RST;
  logic           start_i, op_type_i, op_source_i, write_enable_i;
  logic [A-1:0]   address_i;
  logic [I*L-1:0] alu_result_v_i, rd2_v_i;
  logic [L-1:0]   alu_result_s_i, rd2_s_i;
  logic [A-1:0]   mem_addr_o;
  logic [L-1:0]   mem_wdata_o, mem_rdata_i, scalar_o;
  logic           mem_we_o, mem_finished_o, stall_o;
  logic [I*L-1:0] vector_o;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]  mem [4096];
  logic [7:0]  ref_mem [4096];
  logic [31:0] wlog_a[$];
  logic [7:0]  wlog_d[$];
  logic [31:0] exp_wa[$];
  logic [7:0]  exp_wd[$];
  logic [31:0] exp_vec;
  logic [7:0]  exp_sca;

  vector_mem_sequencer #(.I(I), .L(L), .A(A)) dut (
    .CLK(CLK), .RST(RST), .start_i(start_i), .op_type_i(op_type_i),
    .op_source_i(op_source_i), .write_enable_i(write_enable_i), .address_i(address_i),
    .alu_result_v_i(alu_result_v_i), .rd2_v_i(rd2_v_i), .alu_result_s_i(alu_result_s_i),
    .rd2_s_i(rd2_s_i), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i), .vector_o(vector_o),
    .scalar_o(scalar_o), .mem_finished_o(mem_finished_o), .stall_o(stall_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous data memory (aliased on the low 12 address bits) with a write log.
  always @(posedge CLK) begin
    if (mem_we_o === 1'b1) begin
      mem[mem_addr_o[11:0]] <= mem_wdata_o;
      wlog_a.push_back(mem_addr_o);
      wlog_d.push_back(mem_wdata_o);
    end
    mem_rdata_i <= mem[mem_addr_o[11:0]];
  end

  // Reference: what one request should do to memory and to the result registers.
  task automatic model_apply(input bit vec, input bit we, input bit src, input logic [31:0] base,
                             input logic [31:0] av, input logic [31:0] rv,
                             input logic [7:0] asv, input logic [7:0] rsv, output int lat);
    int n;
    logic [31:0] data;
    logic [31:0] a;
    n = vec ? I : 1;
    data = vec ? (src ? rv : av) : {24'h0, (src ? rsv : asv)};
    exp_wa.delete();
    exp_wd.delete();
    for (int k = 0; k < n; k++) begin
      a = base + 32'(k);
      if (we) begin
        ref_mem[a[11:0]] = data[8*k +: 8];
        exp_wa.push_back(a);
        exp_wd.push_back(data[8*k +: 8]);
      end else if (vec) begin
        exp_vec[8*k +: 8] = ref_mem[a[11:0]];
      end else begin
        exp_sca = ref_mem[a[11:0]];
      end
    end
    lat = n + (we ? 1 : 2);
  endtask

  task automatic run_access(input bit vec, input bit we, input bit src, input logic [31:0] base,
                            input logic [31:0] av, input logic [31:0] rv,
                            input logic [7:0] asv, input logic [7:0] rsv,
                            output int lat, output int fins, output bit stall_ok,
                            output logic [31:0] vec_fin, output logic [7:0] sca_fin);
    wlog_a.delete();
    wlog_d.delete();
    @(negedge CLK);
    op_type_i = vec; write_enable_i = we; op_source_i = src; address_i = base;
    alu_result_v_i = av; rd2_v_i = rv; alu_result_s_i = asv; rd2_s_i = rsv;
    start_i = 1'b1;
    #1;
    stall_ok = (stall_o === 1'b1);
    lat = -1; fins = 0; vec_fin = 'x; sca_fin = 'x;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      start_i = 1'b0;
      #1;
      if (mem_finished_o === 1'b1) begin
        fins++;
        if (lat < 0) begin
          lat = k; vec_fin = vector_o; sca_fin = scalar_o;
        end
      end
      if (lat < 0 || lat == k) stall_ok = stall_ok && (stall_o === 1'b1);
      else if (lat + 1 == k)   stall_ok = stall_ok && (stall_o === 1'b0);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    n_checks++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0h want 0", mem_we_o); end
    n_checks++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %0h want 0", mem_addr_o); end
    n_checks++; if (mem_wdata_o !== 8'h0) begin n_fail++; $display("FAIL reset_wdata: got %0h want 0", mem_wdata_o); end
    n_checks++; if (mem_finished_o !== 1'b0) begin n_fail++; $display("FAIL reset_fin: got %0h want 0", mem_finished_o); end
    n_checks++; if (vector_o !== 32'h0 || scalar_o !== 8'h0) begin n_fail++; $display("FAIL reset_results: got %0h/%0h want 0/0", vector_o, scalar_o); end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0h want 0", stall_o); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_vector_store();
    int lat, fins, mlat; bit sok; logic [31:0] vf; logic [7:0] sf;
    logic [31:0] ea[4];
    logic [7:0]  ed[4];
    ea = '{32'h10, 32'h11, 32'h12, 32'h13};
    ed = '{8'h11, 8'h22, 8'h33, 8'h44};
    model_apply(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h44332211, 8'h0, 8'h0, mlat);
    run_access(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h44332211, 8'h0, 8'h0, lat, fins, sok, vf, sf);
    n_checks++; if (lat != 5) begin n_fail++; $display("FAIL vst_latency: got %0d want 5", lat); end
    n_checks++; if (fins != 1) begin n_fail++; $display("FAIL vst_pulses: got %0d want 1", fins); end
    n_checks++; if (!sok) begin n_fail++; $display("FAIL vst_stall: got bad window want high t0..t0+5"); end
    n_checks++;
    if (wlog_a.size() != 4) begin n_fail++; $display("FAIL vst_nwrites: got %0d want 4", wlog_a.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (wlog_a[k] !== ea[k] || wlog_d[k] !== ed[k]) begin
          n_fail++; $display("FAIL vst_write%0d: got %0h@%0h want %0h@%0h", k, wlog_d[k], wlog_a[k], ed[k], ea[k]);
        end
      end
    end
  endtask

  task automatic test_vector_load();
    int lat, fins, mlat; bit sok; logic [31:0] vf; logic [7:0] sf;
    model_apply(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 8'h0, 8'h0, mlat);
    run_access(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 8'h0, 8'h0, lat, fins, sok, vf, sf);
    n_checks++; if (lat != 6) begin n_fail++; $display("FAIL vld_latency: got %0d want 6", lat); end
    n_checks++; if (fins != 1) begin n_fail++; $display("FAIL vld_pulses: got %0d want 1", fins); end
    n_checks++; if (vf !== 32'h44332211) begin n_fail++; $display("FAIL vld_data: got %0h want 44332211", vf); end
    n_checks++; if (wlog_a.size() != 0) begin n_fail++; $display("FAIL vld_we: got %0d writes want 0", wlog_a.size()); end
    n_checks++; if (!sok) begin n_fail++; $display("FAIL vld_stall: got bad window want high t0..t0+6"); end
  endtask

  task automatic test_scalar();
    int lat, fins, mlat; bit sok; logic [31:0] vf; logic [7:0] sf;
    model_apply(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 8'hA5, 8'h3C, mlat);
    run_access(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 8'hA5, 8'h3C, lat, fins, sok, vf, sf);
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL sst_latency: got %0d want 2", lat); end
    n_checks++;
    if (wlog_a.size() != 1 || wlog_a[0] !== 32'h20 || wlog_d[0] !== 8'hA5) begin
      n_fail++; $display("FAIL sst_write: got %0d writes first %0h@%0h want a5@20", wlog_a.size(), wlog_d[0], wlog_a[0]);
    end
    model_apply(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 32'h0, 8'h0, 8'h0, mlat);
    run_access(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 32'h0, 8'h0, 8'h0, lat, fins, sok, vf, sf);
    n_checks++; if (lat != 3) begin n_fail++; $display("FAIL sld_latency: got %0d want 3", lat); end
    n_checks++; if (sf !== 8'hA5) begin n_fail++; $display("FAIL sld_data: got %0h want a5", sf); end
    n_checks++; if (vf !== 32'h44332211) begin n_fail++; $display("FAIL sld_vec_held: got %0h want 44332211", vf); end
  endtask

  task automatic test_wrap();
    int lat, fins, mlat; bit sok; logic [31:0] vf; logic [7:0] sf; logic [31:0] d;
    logic [31:0] ea[4];
    ea = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
    d = $urandom();
    model_apply(1'b1, 1'b1, 1'b0, 32'hFFFFFFFE, d, 32'h0, 8'h0, 8'h0, mlat);
    run_access(1'b1, 1'b1, 1'b0, 32'hFFFFFFFE, d, 32'h0, 8'h0, 8'h0, lat, fins, sok, vf, sf);
    n_checks++;
    if (wlog_a.size() != 4) begin n_fail++; $display("FAIL wrap_nwrites: got %0d want 4", wlog_a.size()); end
    else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (wlog_a[k] !== ea[k] || wlog_d[k] !== d[8*k +: 8]) begin
          n_fail++; $display("FAIL wrap_write%0d: got %0h@%0h want %0h@%0h", k, wlog_d[k], wlog_a[k], d[8*k +: 8], ea[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    int fin_k[$];
    bit idle_stall;
    logic [31:0] d;
    d = $urandom();
    idle_stall = 1'b0;
    model_apply(1'b1, 1'b1, 1'b1, 32'h30, 32'h0, d, 8'h0, 8'h0, lat1);
    wlog_a.delete(); wlog_d.delete();
    @(negedge CLK);
    op_type_i = 1'b1; write_enable_i = 1'b1; op_source_i = 1'b1; address_i = 32'h30;
    rd2_v_i = d; alu_result_v_i = ~d; start_i = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge CLK);
      if (k == lat1 + 1) write_enable_i = 1'b0;
      if (k == lat1 + 2) start_i = 1'b0;
      #1;
      if (mem_finished_o === 1'b1) fin_k.push_back(k);
      if (k == lat1 + 1) idle_stall = (stall_o === 1'b1);
    end
    model_apply(1'b1, 1'b0, 1'b1, 32'h30, 32'h0, 32'h0, 8'h0, 8'h0, lat2);
    n_checks++;
    if (fin_k.size() != 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d want 2", fin_k.size()); end
    else begin
      n_checks++; if (fin_k[0] != lat1) begin n_fail++; $display("FAIL b2b_first: got %0d want %0d", fin_k[0], lat1); end
      n_checks++; if (fin_k[1] != lat1 + 1 + lat2) begin n_fail++; $display("FAIL b2b_second: got %0d want %0d", fin_k[1], lat1 + 1 + lat2); end
    end
    n_checks++; if (wlog_a.size() != 4) begin n_fail++; $display("FAIL b2b_nwrites: got %0d want 4", wlog_a.size()); end
    n_checks++; if (vector_o !== exp_vec) begin n_fail++; $display("FAIL b2b_vec: got %0h want %0h", vector_o, exp_vec); end
    n_checks++; if (!idle_stall) begin n_fail++; $display("FAIL b2b_idle_stall: got 0 want 1"); end
  endtask

  task automatic test_random();
    int lat, fins, mlat; bit sok; logic [31:0] vf; logic [7:0] sf;
    bit vec, we, src; logic [31:0] base, av, rv; logic [7:0] asv, rsv;
    int bad;
    for (int it = 0; it < 24; it++) begin
      vec = 1'($urandom()); we = 1'($urandom()); src = 1'($urandom());
      base = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3)))
                                         : (32'h400 + 32'($urandom_range(0, 12)));
      av = $urandom(); rv = $urandom(); asv = 8'($urandom()); rsv = 8'($urandom());
      model_apply(vec, we, src, base, av, rv, asv, rsv, mlat);
      run_access(vec, we, src, base, av, rv, asv, rsv, lat, fins, sok, vf, sf);
      n_checks++; if (lat != mlat) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", it, lat, mlat); end
      n_checks++; if (fins != 1) begin n_fail++; $display("FAIL rnd%0d_pulses: got %0d want 1", it, fins); end
      n_checks++; if (!sok) begin n_fail++; $display("FAIL rnd%0d_stall: got bad window want high t0..t0+%0d", it, mlat); end
      bad = (wlog_a.size() != exp_wa.size()) ? 1 : 0;
      for (int k = 0; k < exp_wa.size() && bad == 0; k++) begin
        if (wlog_a[k] !== exp_wa[k] || wlog_d[k] !== exp_wd[k]) bad = 1;
      end
      n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rnd%0d_writes: got %0d writes want %0d at base %0h", it, wlog_a.size(), exp_wa.size(), base); end
      n_checks++; if (vf !== exp_vec) begin n_fail++; $display("FAIL rnd%0d_vec: got %0h want %0h", it, vf, exp_vec); end
      n_checks++; if (sf !== exp_sca) begin n_fail++; $display("FAIL rnd%0d_sca: got %0h want %0h", it, sf, exp_sca); end
    end
  endtask

  task automatic test_reset_abort();
    int lat, fins, mlat, pulses; bit sok; logic [31:0] vf; logic [7:0] sf; logic [31:0] d;
    d = $urandom();
    pulses = 0;
    wlog_a.delete(); wlog_d.delete();
    @(negedge CLK);
    op_type_i = 1'b1; write_enable_i = 1'b1; op_source_i = 1'b1; address_i = 32'h200;
    rd2_v_i = d; start_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      start_i = 1'b0;
    end
    #1;
    n_checks++; if (mem_we_o !== 1'b1 || mem_addr_o !== 32'h202) begin n_fail++; $display("FAIL abort_pre: got we %0h addr %0h want 1 202", mem_we_o, mem_addr_o); end
    RST = 1'b1;
    #1;
    n_checks++; if (mem_we_o !== 1'b0) begin n_fail++; $display("FAIL abort_we: got %0h want 0", mem_we_o); end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got stall %0h want 0", stall_o); end
    n_checks++; if (vector_o !== 32'h0) begin n_fail++; $display("FAIL abort_vec: got %0h want 0", vector_o); end
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge CLK);
      if (mem_finished_o === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL abort_pulse: got %0d want 0", pulses); end
    n_checks++;
    if (wlog_a.size() != 2 || wlog_a[0] !== 32'h200 || wlog_d[0] !== d[7:0] || wlog_a[1] !== 32'h201 || wlog_d[1] !== d[15:8]) begin
      n_fail++; $display("FAIL abort_writes: got %0d writes want 2 (%0h@200 %0h@201)", wlog_a.size(), d[7:0], d[15:8]);
    end
    ref_mem[12'h200] = d[7:0];
    ref_mem[12'h201] = d[15:8];
    exp_vec = 32'h0;
    exp_sca = 8'h0;
    model_apply(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'h0, 8'h0, 8'h0, mlat);
    run_access(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 32'h0, 8'h0, 8'h0, lat, fins, sok, vf, sf);
    n_checks++; if (vf !== exp_vec) begin n_fail++; $display("FAIL abort_reload: got %0h want %0h", vf, exp_vec); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    for (int a = 0; a < 4096; a++) begin
      mem[a] = 8'h00;
      ref_mem[a] = 8'h00;
    end
    RST = 1'b1; start_i = 1'b0; op_type_i = 1'b0; op_source_i = 1'b0; write_enable_i = 1'b0;
    address_i = 32'h0; alu_result_v_i = 32'h0; rd2_v_i = 32'h0; alu_result_s_i = 8'h0; rd2_s_i = 8'h0;
    exp_vec = 32'h0; exp_sca = 8'h0;
    test_reset();
    test_vector_store();
    test_vector_load();
    test_scalar();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
